key_debounce_n: RTL and testbench

Parametrised multi-channel push-button conditioner for the lock board's key inputs. It synchronises CH raw button lines into the myclk domain and accepts a level change only after STABLE consecutive agreeing samples taken every DIV cycles. Per channel it emits a debounced level, single-cycle press and release strobes, and a long-press flag. It sits between the board pins and the password-entry FSM.

---
 rtl/key_debounce_pkg.sv | 14 +
 rtl/key_debounce_chan.sv | 73 +++++++
 rtl/key_debounce_n.sv | 67 ++++++
 tb/tb_key_debounce_n.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared width helper and parameter limits
// for the key input conditioner.
package key_debounce_pkg;

   localparam int MIN_DIV    = 1;
   localparam int MIN_STABLE = 1;
   localparam int MIN_HOLD   = 1;

   // Counter width for values 0..n-1, never below one bit.
   function automatic int cw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// key_debounce_chan: one button channel -- synchroniser,
// stability filter, press/release strobes and long-press flag.
module key_debounce_chan
   import key_debounce_pkg::*;
#(
   parameter int STABLE     = 3,
   parameter int HOLD       = 8,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic myclk,
   input  logic rst,
   input  logic tick,
   input  logic button,
   output logic level,
   output logic rise,
   output logic fall,
   output logic held
);

   localparam int CW = cw(STABLE);
   localparam int HW = cw(HOLD + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD);

   logic          raw;
   logic          sync1;
   logic          s;
   logic          state;
   logic [CW-1:0] cnt;
   logic [HW-1:0] hcnt;
   logic          accept;

   assign raw    = ACTIVE_LOW ? ~button : button;
   assign accept = tick && (s != state) && (cnt == CNT_MAX);
   assign level  = state;

   always_ff @(posedge myclk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
         state <= 1'b0;
         cnt   <= '0;
         hcnt  <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
         held  <= 1'b0;
      end else begin
         sync1 <= raw;
         s     <= sync1;
         // strobes land in the same cycle the new level appears
         rise  <= accept && s;
         fall  <= accept && !s;
         if (tick) begin
            if (s == state) begin
               cnt <= '0;
            end else if (accept) begin
               state <= s;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
         if (accept && !s) begin
            hcnt <= '0;
            held <= 1'b0;
         end else if (tick && state && (hcnt != HOLD_MAX)) begin
            hcnt <= hcnt + HW'(1);
            held <= ((hcnt + HW'(1)) == HOLD_MAX);
         end
      end
   end

endmodule

// File: rtl/key_debounce_n.sv
// key_debounce_n: CH-channel push-button conditioner with a
// shared sample tick feeding independent debounce channels.
module key_debounce_n
   import key_debounce_pkg::*;
#(
   parameter int CH         = 4,
   parameter int DIV        = 4,
   parameter int STABLE     = 3,
   parameter int HOLD       = 8,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic          myclk,
   input  logic          rst,
   input  logic [CH-1:0] button,
   output logic [CH-1:0] level,
   output logic [CH-1:0] rise,
   output logic [CH-1:0] fall,
   output logic [CH-1:0] held
);

   localparam int TW = cw(DIV);
   localparam logic [TW-1:0] TMAX = TW'(DIV - 1);

   if (DIV < MIN_DIV) begin : g_bad_div
      $error("key_debounce_n: DIV must be >= 1");
   end
   if (STABLE < MIN_STABLE) begin : g_bad_stable
      $error("key_debounce_n: STABLE must be >= 1");
   end
   if (HOLD < MIN_HOLD) begin : g_bad_hold
      $error("key_debounce_n: HOLD must be >= 1");
   end

   logic [TW-1:0] tcnt;
   logic          tick;

   // DIV=1 leaves tcnt pinned at 0, so tick stays high
   assign tick = (tcnt == TMAX);

   always_ff @(posedge myclk or posedge rst) begin
      if (rst) begin
         tcnt <= '0;
      end else if (tick) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + TW'(1);
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      key_debounce_chan #(
         .STABLE     (STABLE),
         .HOLD       (HOLD),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_chan (
         .myclk  (myclk),
         .rst    (rst),
         .tick   (tick),
         .button (button[i]),
         .level  (level[i]),
         .rise   (rise[i]),
         .fall   (fall[i]),
         .held   (held[i])
      );
   end

endmodule

// File: tb/tb_key_debounce_n.sv
// tb_key_debounce_n: directed scenarios plus random bouncing,
// checked each cycle against a sample-history reference model.
module tb_key_debounce_n;

   logic       myclk = 1'b0;
   logic       rst;
   logic [3:0] btn, lvl, rs, fl, hd;
   logic [3:0] btn2, lvl2, rs2, fl2, hd2;
   bit         chk_en = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 myclk = ~myclk;

   key_debounce_n u_dut (
      .myclk  (myclk),
      .rst    (rst),
      .button (btn),
      .level  (lvl),
      .rise   (rs),
      .fall   (fl),
      .held   (hd)
   );

   key_debounce_n #(
      .CH(4), .DIV(1), .STABLE(1), .HOLD(3), .ACTIVE_LOW(1'b1)
   ) u_dut2 (
      .myclk  (myclk),
      .rst    (rst),
      .button (btn2),
      .level  (lvl2),
      .rise   (rs2),
      .fall   (fl2),
      .held   (hd2)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: each channel keeps the bit history of its
   // tick samples; a change is accepted once the last STABLE
   // samples all disagree with the current level.
   int         P_DIV [2] = '{4, 1};
   int         P_STB [2] = '{3, 1};
   int         P_HLD [2] = '{8, 3};
   bit         P_AL  [2] = '{1'b0, 1'b1};
   int         m_n   [2];
   logic [3:0] m_s1  [2];
   logic [3:0] m_s2  [2];
   logic [3:0] m_st  [2];
   logic [3:0] m_rs  [2];
   logic [3:0] m_fl  [2];
   int         m_hc  [2][4];
   int         m_hist[2][4];
   int         m_nh  [2][4];

   function automatic void mreset(input int k);
      m_n[k]  = 0;
      m_s1[k] = '0;
      m_s2[k] = '0;
      m_st[k] = '0;
      m_rs[k] = '0;
      m_fl[k] = '0;
      for (int c = 0; c < 4; c++) begin
         m_hc[k][c]   = 0;
         m_hist[k][c] = 0;
         m_nh[k][c]   = 0;
      end
   endfunction

   function automatic void mstep(input int k, input logic [3:0] raw);
      bit tk;
      int mask;
      int want;
      tk   = (m_n[k] % P_DIV[k]) == (P_DIV[k] - 1);
      mask = (1 << P_STB[k]) - 1;
      m_rs[k] = '0;
      m_fl[k] = '0;
      if (tk) begin
         for (int c = 0; c < 4; c++) begin
            m_hist[k][c] = ((m_hist[k][c] << 1) | int'(m_s2[k][c])) & 'hFFFF;
            if (m_nh[k][c] < 16) m_nh[k][c]++;
            want = m_st[k][c] ? 0 : mask;
            if (m_nh[k][c] >= P_STB[k] && (m_hist[k][c] & mask) == want) begin
               m_st[k][c] = ~m_st[k][c];
               if (m_st[k][c]) begin
                  m_rs[k][c] = 1'b1;
               end else begin
                  m_fl[k][c] = 1'b1;
                  m_hc[k][c] = 0;
               end
            end else if (m_st[k][c] && m_hc[k][c] < P_HLD[k]) begin
               m_hc[k][c]++;
            end
         end
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = P_AL[k] ? ~raw : raw;
      m_n[k]++;
   endfunction

   function automatic logic [3:0] exp_held(input int k);
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = (m_hc[k][c] == P_HLD[k]);
      return v;
   endfunction

   always @(posedge myclk or posedge rst) begin
      if (rst) begin
         mreset(0);
         mreset(1);
      end else begin
         mstep(0, btn);
         mstep(1, btn2);
      end
   end

   always @(negedge myclk) begin
      if (!rst && chk_en) begin
         chk("level_a", 32'(lvl), 32'(m_st[0]));
         chk("rise_a",  32'(rs),  32'(m_rs[0]));
         chk("fall_a",  32'(fl),  32'(m_fl[0]));
         chk("held_a",  32'(hd),  32'(exp_held(0)));
         chk("level_b", 32'(lvl2), 32'(m_st[1]));
         chk("rise_b",  32'(rs2),  32'(m_rs[1]));
         chk("fall_b",  32'(fl2),  32'(m_fl[1]));
         chk("held_b",  32'(hd2),  32'(exp_held(1)));
      end
   end

   int rcnt[4] = '{default: 0};
   int fcnt[4] = '{default: 0};
   int acnt[4] = '{default: 0};

   always @(negedge myclk) begin
      if (!rst) begin
         for (int c = 0; c < 4; c++) begin
            rcnt[c] += int'(rs[c]);
            fcnt[c] += int'(fl[c]);
            acnt[c] += int'(lvl[c] | rs[c] | fl[c] | hd[c]);
         end
      end
   end

   function automatic logic [3:0] sig(input int w);
      case (w)
         0:       return lvl;
         1:       return rs;
         2:       return fl;
         3:       return hd;
         4:       return lvl2;
         default: return fl2;
      endcase
   endfunction

   task automatic wait_hi(input int w, input int c, input int lim,
                          output int lat);
      logic [3:0] v;
      lat = -1;
      for (int i = 1; i <= lim; i++) begin
         @(negedge myclk);
         v = sig(w);
         if (v[c]) begin
            lat = i;
            break;
         end
      end
   endtask

   int lat, lat2, base, basef;
   int p;

   initial begin
      btn  = 4'h0;
      btn2 = 4'hF;
      rst  = 1'b1;
      repeat (3) @(negedge myclk);
      chk("reset_outs", {16'h0, lvl, rs, fl, hd, lvl2, rs2, fl2, hd2}, 32'h0);
      #2 rst = 1'b0;
      chk_en = 1'b1;
      repeat (10) @(negedge myclk);

      // clean press and release on ch0
      #1 base = rcnt[0];
      basef = fcnt[0];
      btn[0] = 1'b1;
      wait_hi(0, 0, 30, lat);
      chk($sformatf("press_lat=%0d", lat), 32'(lat >= 11 && lat <= 14), 32'h1);
      repeat (60 - lat) @(negedge myclk);
      btn[0] = 1'b0;
      wait_hi(2, 0, 30, lat);
      chk($sformatf("release_lat=%0d", lat), 32'(lat >= 11 && lat <= 14), 32'h1);
      repeat (5) @(negedge myclk);
      #1 chk("ch0_rise_count", 32'(rcnt[0] - base), 32'h1);
      chk("ch0_fall_count", 32'(fcnt[0] - basef), 32'h1);

      // bounce on ch1
      base = rcnt[1];
      for (int i = 0; i < 2; i++) begin
         btn[1] = 1'b1;
         repeat (4) @(negedge myclk);
         btn[1] = 1'b0;
         repeat (4) @(negedge myclk);
      end
      btn[1] = 1'b1;
      wait_hi(1, 1, 30, lat);
      chk($sformatf("bounce_lat=%0d", lat), 32'(lat >= 11 && lat <= 14), 32'h1);
      repeat (3) @(negedge myclk);
      #1 chk("bounce_rise_count", 32'(rcnt[1] - base), 32'h1);

      // short glitch on ch2
      base = acnt[2];
      btn[2] = 1'b1;
      repeat (8) @(negedge myclk);
      btn[2] = 1'b0;
      repeat (30) @(negedge myclk);
      #1 chk("glitch_activity", 32'(acnt[2] - base), 32'h0);

      // long press on ch3
      btn[3] = 1'b1;
      wait_hi(1, 3, 30, lat);
      wait_hi(3, 3, 50, lat2);
      chk("held_after_rise", 32'(lat2), 32'd32);
      repeat (100 - lat - lat2) @(negedge myclk);
      chk("held_sustained", 32'(hd[3]), 32'h1);
      btn[3] = 1'b0;
      wait_hi(2, 3, 30, lat);
      chk("release_drops", {30'h0, lvl[3], hd[3]}, 32'h0);

      // simultaneous press, then reset during a pending release
      btn = 4'h0;
      repeat (20) @(negedge myclk);
      btn = 4'hF;
      for (int i = 0; i < 30; i++) begin
         @(negedge myclk);
         if (rs != 4'h0) break;
      end
      chk("simul_rise", 32'(rs), 32'hF);
      repeat (20) @(negedge myclk);
      btn = 4'h0;
      repeat (6) @(negedge myclk);
      #2 rst = 1'b1;
      #1 chk("async_reset", {16'h0, lvl, rs, fl, hd}, 32'h0);
      btn = 4'hF;
      @(negedge myclk);
      @(negedge myclk);
      #2 rst = 1'b0;
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge myclk);
         if (rs != 4'h0) begin
            lat = i;
            break;
         end
      end
      chk("post_reset_rise", 32'(rs), 32'hF);
      chk($sformatf("post_reset_lat=%0d", lat), 32'(lat >= 11 && lat <= 14), 32'h1);

      // active-low, DIV=1, STABLE=1 instance
      @(negedge myclk);
      btn2[0] = 1'b0;
      wait_hi(4, 0, 6, lat);
      chk($sformatf("al_press_lat=%0d", lat), 32'(lat >= 1 && lat <= 4), 32'h1);
      repeat (5) @(negedge myclk);
      btn2[0] = 1'b1;
      wait_hi(5, 0, 6, lat);
      chk($sformatf("al_release_lat=%0d", lat), 32'(lat >= 1 && lat <= 4), 32'h1);

      // random bouncing with varying toggle density
      for (int seg = 0; seg < 6; seg++) begin
         p = $urandom_range(2, 40);
         for (int i = 0; i < 500; i++) begin
            @(negedge myclk);
            for (int c = 0; c < 4; c++) begin
               if ($urandom_range(0, p) == 0) btn[c] = ~btn[c];
               if ($urandom_range(0, p) == 0) btn2[c] = ~btn2[c];
            end
         end
      end

      repeat (20) @(negedge myclk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
